// File: rtl/fir_multichannel_engine.sv
// fir_multichannel_engine
//   Time-multiplexed FIR engine: CHANNELS sample streams are filtered with
//   TAPS-tap filters on one shared multiply-accumulate unit. Each channel
//   chooses one of BANKS runtime-writable coefficient banks per sample set.
//
// Ports
//   sys_clk, rst_n           single rising-edge clock, synchronous active-low reset
//   sample_valid/ready       sample-set handshake; sample_in packed, ch0 in LSBs
//   bank_sel                 per-channel bank select, latched with the sample set
//   flush                    zero all delay lines (only while idle, no sample offered)
//   coeff_we/ready           coefficient write handshake (coeff_ready == sample_ready)
//   coeff_ch/bank/idx/val    coefficient write target and value (idx 0 = newest sample)
//   result_valid             one-cycle pulse when result_out/sat_flag update
//   result_out               packed signed results, held until the next pulse
//   busy                     high from the accept edge through the result_valid cycle
//   sat_flag                 per-channel: last result was clipped
//
// Handshakes: a transfer happens at a rising edge where valid (or coeff_we) and
// ready are both high. Ready depends only on engine state, never on valid.
// The requester holds its request and payload stable until that edge.
module fir_multichannel_engine #(
    parameter int CHANNELS = 3,
    parameter int TAPS     = 16,
    parameter int BANKS    = 4,
    parameter int DATA_W   = 16,
    parameter int COEFF_W  = 18,
    parameter int FRAC     = 16,
    localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    localparam int BANK_W  = (BANKS > 1) ? $clog2(BANKS) : 1,
    localparam int TAP_W   = $clog2(TAPS)
) (
    input  logic                       sys_clk,
    input  logic                       rst_n,
    input  logic                       sample_valid,
    output logic                       sample_ready,
    input  logic [CHANNELS*DATA_W-1:0] sample_in,
    input  logic [CHANNELS*BANK_W-1:0] bank_sel,
    input  logic                       flush,
    input  logic                       coeff_we,
    output logic                       coeff_ready,
    input  logic [CH_W-1:0]            coeff_ch,
    input  logic [BANK_W-1:0]          coeff_bank,
    input  logic [TAP_W-1:0]           coeff_idx,
    input  logic [COEFF_W-1:0]         coeff_val,
    output logic                       result_valid,
    output logic [CHANNELS*DATA_W-1:0] result_out,
    output logic                       busy,
    output logic [CHANNELS-1:0]        sat_flag
);

    localparam int PW     = DATA_W + COEFF_W;
    localparam int AW     = PW + TAP_W;
    localparam int CMEM_W = CHANNELS * BANKS * TAPS * COEFF_W;
    localparam logic signed [AW-1:0] RES_MAX = AW'((longint'(1) << (DATA_W - 1)) - 1);
    localparam logic signed [AW-1:0] RES_MIN = ~RES_MAX;

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_MAC, S_OUT} state_t;

    function automatic int coeff_base(input int c, input int b, input int t);
        return ((c * BANKS + b) * TAPS + t) * COEFF_W;
    endfunction

    // Power-up bank contents: 0 = pass-through, 1 = moving average,
    // 2 = 0.25 on taps 2..5, 3 = all zero.
    function automatic logic [CMEM_W-1:0] default_coeffs();
        logic [CMEM_W-1:0]  m;
        logic [COEFF_W-1:0] v;
        m = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            for (int b = 0; b < BANKS; b++) begin
                for (int t = 0; t < TAPS; t++) begin
                    v = '0;
                    if (b == 0 && t == 0) v = COEFF_W'(longint'(1) << FRAC);
                    if (b == 1)           v = COEFF_W'((longint'(1) << FRAC) / TAPS);
                    if (b == 2 && t >= 2 && t <= 5) v = COEFF_W'(longint'(1) << (FRAC - 2));
                    m[coeff_base(c, b, t) +: COEFF_W] = v;
                end
            end
        end
        return m;
    endfunction

    // Coefficients survive reset; only the power-up value is defined.
    logic [CMEM_W-1:0] coeff_mem = default_coeffs();

    state_t                       state_q, state_d;
    logic [CHANNELS*DATA_W-1:0]   sample_q;
    logic [CHANNELS*BANK_W-1:0]   bank_q;
    logic signed [DATA_W-1:0]     dly [CHANNELS][TAPS];
    logic [CH_W-1:0]              ch_q;
    logic [TAP_W-1:0]             tap_q;
    logic signed [AW-1:0]         acc_q;
    logic [CHANNELS*DATA_W-1:0]   stage_q;
    logic [CHANNELS-1:0]          stage_sat_q;

    logic accept, do_flush, shift_en, mac_en, out_en, coeff_wr;
    logic tap_last, ch_last;

    logic [BANK_W-1:0]         bank_cur;
    logic signed [DATA_W-1:0]  dly_cur;
    logic signed [COEFF_W-1:0] coeff_cur;
    logic signed [PW-1:0]      prod;
    logic signed [AW-1:0]      acc_sum, res_full;
    logic                      res_hi, res_lo;
    logic [DATA_W-1:0]         res_clip;

    assign tap_last = (tap_q == TAP_W'(TAPS - 1));
    assign ch_last  = (ch_q == CH_W'(CHANNELS - 1));

    // State register
    always_ff @(posedge sys_clk) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (sample_valid) state_d = S_SHIFT;
            S_SHIFT: state_d = S_MAC;
            S_MAC:   if (tap_last && ch_last) state_d = S_OUT;
            S_OUT:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State-decoded outputs and enables. busy stays high through the
    // result_valid cycle even though the FSM is already back in IDLE.
    always_comb begin
        sample_ready = (state_q == S_IDLE);
        coeff_ready  = sample_ready;
        busy         = (state_q != S_IDLE) || result_valid;
        accept       = sample_ready && sample_valid;
        do_flush     = sample_ready && !sample_valid && flush;
        shift_en     = (state_q == S_SHIFT);
        mac_en       = (state_q == S_MAC);
        out_en       = (state_q == S_OUT);
        coeff_wr     = coeff_we && coeff_ready &&
                       ({1'b0, coeff_ch} < (CH_W + 1)'(CHANNELS));
    end

    // Shared MAC datapath plus result scaling and saturation.
    always_comb begin
        bank_cur  = bank_q[int'(ch_q) * BANK_W +: BANK_W];
        dly_cur   = dly[ch_q][tap_q];
        coeff_cur = coeff_mem[coeff_base(int'(ch_q), int'(bank_cur), int'(tap_q)) +: COEFF_W];
        prod      = PW'(dly_cur) * PW'(coeff_cur);
        acc_sum   = acc_q + AW'(prod);
        res_full  = acc_sum >>> FRAC;
        res_hi    = (res_full > RES_MAX);
        res_lo    = (res_full < RES_MIN);
        res_clip  = res_full[DATA_W-1:0];
        if (res_hi) res_clip = RES_MAX[DATA_W-1:0];
        if (res_lo) res_clip = RES_MIN[DATA_W-1:0];
    end

    always_ff @(posedge sys_clk) begin
        if (coeff_wr)
            coeff_mem[coeff_base(int'(coeff_ch), int'(coeff_bank), int'(coeff_idx)) +: COEFF_W] <= coeff_val;
    end

    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            sample_q     <= '0;
            bank_q       <= '0;
            ch_q         <= '0;
            tap_q        <= '0;
            acc_q        <= '0;
            stage_q      <= '0;
            stage_sat_q  <= '0;
            result_out   <= '0;
            sat_flag     <= '0;
            result_valid <= 1'b0;
            for (int c = 0; c < CHANNELS; c++)
                for (int t = 0; t < TAPS; t++)
                    dly[c][t] <= '0;
        end else begin
            result_valid <= 1'b0;
            if (accept) begin
                sample_q <= sample_in;
                bank_q   <= bank_sel;
            end
            if (do_flush) begin
                for (int c = 0; c < CHANNELS; c++)
                    for (int t = 0; t < TAPS; t++)
                        dly[c][t] <= '0;
            end
            if (shift_en) begin
                for (int c = 0; c < CHANNELS; c++) begin
                    for (int t = TAPS - 1; t > 0; t--)
                        dly[c][t] <= dly[c][t-1];
                    dly[c][0] <= sample_q[c*DATA_W +: DATA_W];
                end
                acc_q <= '0;
                ch_q  <= '0;
                tap_q <= '0;
            end
            if (mac_en) begin
                if (tap_last) begin
                    // Last tap folds straight into the staged result.
                    stage_q[int'(ch_q)*DATA_W +: DATA_W] <= res_clip;
                    stage_sat_q[ch_q] <= res_hi || res_lo;
                    acc_q <= '0;
                    tap_q <= '0;
                    ch_q  <= ch_q + CH_W'(1);
                end else begin
                    acc_q <= acc_sum;
                    tap_q <= tap_q + TAP_W'(1);
                end
            end
            if (out_en) begin
                result_out   <= stage_q;
                sat_flag     <= stage_sat_q;
                result_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fir_multichannel_engine.sv
// Directed bench for fir_multichannel_engine at default parameters.
module tb_fir_multichannel_engine;

    localparam int LATENCY = 50;
    localparam logic [17:0] C_ONE  = 18'h10000;
    localparam logic [17:0] C_HALF = 18'h08000;

    logic        sys_clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sample_valid = 1'b0;
    logic        sample_ready;
    logic [47:0] sample_in = '0;
    logic [5:0]  bank_sel = '0;
    logic        flush = 1'b0;
    logic        coeff_we = 1'b0;
    logic        coeff_ready;
    logic [1:0]  coeff_ch = '0;
    logic [1:0]  coeff_bank = '0;
    logic [3:0]  coeff_idx = '0;
    logic [17:0] coeff_val = '0;
    logic        result_valid;
    logic [47:0] result_out;
    logic        busy;
    logic [2:0]  sat_flag;

    int n_checks = 0;
    int n_pass   = 0;
    logic [15:0] exp_q[$];

    fir_multichannel_engine dut (
        .sys_clk      (sys_clk),
        .rst_n        (rst_n),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .sample_in    (sample_in),
        .bank_sel     (bank_sel),
        .flush        (flush),
        .coeff_we     (coeff_we),
        .coeff_ready  (coeff_ready),
        .coeff_ch     (coeff_ch),
        .coeff_bank   (coeff_bank),
        .coeff_idx    (coeff_idx),
        .coeff_val    (coeff_val),
        .result_valid (result_valid),
        .result_out   (result_out),
        .busy         (busy),
        .sat_flag     (sat_flag)
    );

    // Clock / watchdog
    always #5 sys_clk = ~sys_clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    function automatic int ch_res(input logic [47:0] r, input int ch);
        return int'($signed(r[ch*16 +: 16]));
    endfunction

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Driver tasks
    task automatic accept_set(input int s0, input int s1, input int s2,
                              input logic [5:0] banks, input logic with_flush);
        int waited;
        waited = 0;
        while (!sample_ready && waited < 200) begin
            @(posedge sys_clk); #1; waited++;
        end
        check("ready_before_accept", int'(sample_ready), 1);
        @(negedge sys_clk);
        sample_in    = {16'(s2), 16'(s1), 16'(s0)};
        bank_sel     = banks;
        flush        = with_flush;
        sample_valid = 1'b1;
        @(posedge sys_clk); #1;
        sample_valid = 1'b0;
        flush        = 1'b0;
        check("busy_after_accept", int'(busy), 1);
    endtask

    task automatic wait_result(output logic [47:0] res, output int lat);
        lat = 0;
        while (!result_valid && lat < 200) begin
            @(posedge sys_clk); #1; lat++;
        end
        res = result_out;
    endtask

    task automatic do_set(input int s0, input int s1, input int s2,
                          input logic [5:0] banks, input logic with_flush,
                          output logic [47:0] res);
        int lat;
        accept_set(s0, s1, s2, banks, with_flush);
        wait_result(res, lat);
        check("latency", lat, LATENCY);
    endtask

    task automatic write_coeff(input int ch, input int bank, input int idx,
                               input logic [17:0] val);
        int waited;
        @(negedge sys_clk);
        coeff_we   = 1'b1;
        coeff_ch   = 2'(ch);
        coeff_bank = 2'(bank);
        coeff_idx  = 4'(idx);
        coeff_val  = val;
        waited = 0;
        while (!coeff_ready && waited < 200) begin
            @(negedge sys_clk); waited++;
        end
        @(posedge sys_clk); #1;
        coeff_we = 1'b0;
    endtask

    task automatic do_flush();
        int waited;
        waited = 0;
        while (!sample_ready && waited < 200) begin
            @(posedge sys_clk); #1; waited++;
        end
        @(negedge sys_clk);
        flush = 1'b1;
        @(posedge sys_clk); #1;
        flush = 1'b0;
    endtask

    // Stimulus and scoreboard
    initial begin
        logic [47:0] res;
        int t1_s[3];
        int ready_seen, pulses, n;
        t1_s = '{100, -200, 32767};

        // Reset state
        repeat (3) @(posedge sys_clk);
        #1;
        check("rst_sample_ready", int'(sample_ready), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_result_valid", int'(result_valid), 0);
        check("rst_sat_flag", int'(sat_flag), 0);
        for (int c = 0; c < 3; c++) check("rst_result_out", ch_res(result_out, c), 0);
        rst_n = 1'b1;

        // Pass-through on bank0
        for (int i = 0; i < 3; i++) begin
            do_set(t1_s[i], -5 * (i + 1), 7, 6'h00, 1'b0, res);
            check("pass_ch0", ch_res(res, 0), t1_s[i]);
            check("pass_ch1", ch_res(res, 1), -5 * (i + 1));
            check("pass_ch2", ch_res(res, 2), 7);
            check("pass_sat", int'(sat_flag), 0);
        end

        // Moving average on bank1 (4096 = 1/16 per tap)
        do_flush();
        for (int k = 1; k <= 17; k++) begin
            exp_q.push_back(16'((k <= 16) ? 100 * k : 1600));
            do_set(1600, 0, 0, 6'h01, 1'b0, res);
            check("avg_ch0", ch_res(res, 0), int'($signed(exp_q.pop_front())));
        end

        // Flush together with a sample is dropped; flush alone clears
        do_set(1600, 0, 0, 6'h01, 1'b1, res);
        check("flush_dropped", ch_res(res, 0), 1600);
        do_flush();
        do_set(1600, 0, 0, 6'h01, 1'b0, res);
        check("flush_alone", ch_res(res, 0), 100);

        // Positive saturation on ch1 bank3 loaded with 1.0 everywhere
        for (int t = 0; t < 16; t++) write_coeff(1, 3, t, C_ONE);
        do_flush();
        for (int k = 1; k <= 16; k++) begin
            do_set(1234, 30000, -321, 6'h0C, 1'b0, res);
            check("sat_ch1", ch_res(res, 1), (k == 1) ? 30000 : 32767);
            check("sat_flag", int'(sat_flag), (k == 1) ? 0 : 2);
            check("sat_ch0", ch_res(res, 0), 1234);
            check("sat_ch2", ch_res(res, 2), -321);
        end

        // Negative saturation
        do_flush();
        do_set(0, -30000, 0, 6'h0C, 1'b0, res);
        check("negsat_ch1_a", ch_res(res, 1), -30000);
        check("negsat_flag_a", int'(sat_flag), 0);
        do_set(0, -30000, 0, 6'h0C, 1'b0, res);
        check("negsat_ch1_b", ch_res(res, 1), -32768);
        check("negsat_flag_b", int'(sat_flag), 2);

        // Floor rounding (bank1, sample -1) and bank2 taps 2..5 = 0.25
        do_flush();
        for (int k = 1; k <= 3; k++) begin
            do_set(-1, 0, 400, 6'h21, 1'b0, res);
            check("floor_ch0", ch_res(res, 0), -1);
            check("bank2_ch2", ch_res(res, 2), (k == 3) ? 100 : 0);
        end

        // Coefficient write while busy: held off until idle
        accept_set(1000, 0, 0, 6'h00, 1'b0);
        repeat (4) @(posedge sys_clk);
        @(negedge sys_clk);
        coeff_we   = 1'b1;
        coeff_ch   = 2'd0;
        coeff_bank = 2'd0;
        coeff_idx  = 4'd0;
        coeff_val  = C_HALF;
        ready_seen = 0;
        n = 0;
        while (!result_valid && n < 200) begin
            if (coeff_ready) ready_seen++;
            @(posedge sys_clk); #1; n++;
        end
        check("busy_wr_ready_low", ready_seen, 0);
        check("busy_wr_result_valid", int'(result_valid), 1);
        check("busy_wr_ready_at_idle", int'(coeff_ready), 1);
        check("busy_wr_old_coeff", ch_res(result_out, 0), 1000);
        @(posedge sys_clk); #1;
        coeff_we = 1'b0;
        do_set(1000, 0, 0, 6'h00, 1'b0, res);
        check("busy_wr_new_coeff", ch_res(res, 0), 500);
        write_coeff(0, 0, 0, C_ONE);

        // Reset in the middle of MAC
        accept_set(500, 0, 0, 6'h00, 1'b0);
        repeat (20) @(posedge sys_clk);
        rst_n = 1'b0;
        @(posedge sys_clk); #1;
        check("midrst_result_valid", int'(result_valid), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_ready", int'(sample_ready), 1);
        check("midrst_result_out", ch_res(result_out, 0), 0);
        rst_n = 1'b1;
        pulses = 0;
        repeat (60) begin
            @(posedge sys_clk); #1;
            if (result_valid) pulses++;
        end
        check("midrst_no_pulse", pulses, 0);
        do_set(160, 50, 0, 6'h0D, 1'b0, res);
        check("midrst_dly_cleared", ch_res(res, 0), 10);
        check("midrst_coeff_kept", ch_res(res, 1), 50);
        do_set(777, 0, 0, 6'h00, 1'b0, res);
        check("midrst_pass", ch_res(res, 0), 777);

        // Final report
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
